wfg_record_pat: RTL and testbench
=================================

// Module: wfg_record_pat
//
// PURPOSE
// - Receive-side counterpart of the pattern driver. Samples CHANNELS serial pattern lines and
//   decodes RZ / RO / NRZ / RC back into one data bit per channel per pattern cycle.
// - Checks the return level of each channel and emits one data word per cycle on an
//   AXI-Stream master.
// - Sits between the external pins (or a loopback from wfg_drive_pat) and the recording
//   / stream sink.
//
// PARAMETERS
// - CHANNELS     32  number of pattern lines; 1..32
// - SYNC_STAGES  2   synchronizer flops per line; >=2
// - FIFO_DEPTH   4   output word FIFO entries; power of two, >=2
//
// PORTS
// - clk                      in   1            system clock
// - rst_n                    in   1            asynchronous active-low reset
// - pat_subcycle_cnt_i       in   8            subcycle counter from the pattern timer
// - ctrl_en_q_i              in   1            block enable
// - patsel_q_i               in   2*CHANNELS   per-channel mode [2c+1:2c]: 00 RZ, 01 RO, 10 NRZ, 11 RC
// - cfg_begin_q_i            in   8            subcycle at which data is sampled
// - cfg_end_q_i              in   8            subcycle at which return level is checked
// - pat_i                    in   CHANNELS     asynchronous pattern lines
// - wfg_axis_tdata_o         out  32           decoded word; bit c = channel c; bits >= CHANNELS are 0
// - wfg_axis_tvalid_o        out  1            FIFO not empty
// - wfg_axis_tready_i        in   1            sink ready
// - err_o                    out  CHANNELS     sticky return-level violation, per channel
// - ovf_o                    out  1            sticky: a word was dropped because the FIFO was full
//
// BEHAVIOUR
// - Reset values: all outputs 0. FIFO empty. Synchronizers, sample regs and count pipeline 0.
//   prev_vld = 0.
// - Alignment: pat_i passes through SYNC_STAGES flops. pat_subcycle_cnt_i is delayed by the
//   same SYNC_STAGES clocks to give cnt_d, so decode sees line and count aligned.
// - Event detect: cnt_prev holds cnt_d from the previous clock.
//   - new = !prev_vld || (cnt_d != cnt_prev).
//   - hit_begin = new && (cnt_d == cfg_begin_q_i).
//   - hit_end = new && (cnt_d == cfg_end_q_i).
//   - Each hit lasts exactly one clock per pattern cycle, however many clocks a subcycle spans.
// - hit_begin: smp[c] <= synced line c, for all channels.
// - hit_end, per channel, expected level:
//   - RZ: 0
//   - RO: 1
//   - NRZ: smp[c]
//   - RC: !smp[c]
//   - If line != expected, set err_o[c].
//   - Push word {zeros, smp} into the FIFO.
// - cfg_begin == cfg_end: sample and push in the same clock. The pushed word carries the
//   newly sampled bits. No check, so err_o is unchanged.
// - FIFO:
//   - Push on hit_end; pop on tvalid && tready.
//   - Full and push without pop: word dropped, ovf_o <= 1, no FIFO state change.
//   - Full and push with pop in the same clock: both accepted; count unchanged.
//   - Empty and push: word visible on tdata/tvalid the next clock. Latency is
//     SYNC_STAGES + 1 clocks from the end-subcycle count change.
//   - tdata is stable while tvalid && !tready.
// - ctrl_en_q_i low (synchronous):
//   - FIFO flushed, tvalid = 0.
//   - err_o and ovf_o cleared.
//   - prev_vld = 0; hits suppressed.
//   - Synchronizers keep running.
// - ctrl_en_q_i rising: decoding starts at the next qualifying count change. A partially
//   sampled cycle (begin hit missed) still pushes at end, with smp = 0 from the clear.
// - Config or patsel change mid-cycle takes effect at the next hit; there is no shadowing.
// - Async reset mid-operation returns everything to reset values immediately; a word in
//   flight is lost.
//
// STRUCTURE
// - wfg_record_pkg:
//   - patsel_e enum: PAT_RZ=2'b00, PAT_RO, PAT_NRZ, PAT_RC
//   - AXIS_DATA_W = 32
// - Sub-module wfg_record_pat_channel, one per channel:
//   - synchronizer, smp flop, expected-level compare, sticky err
//   - inputs: hit_begin, hit_end, ctrl_en, patsel
// - Top level: count delay pipeline, event detect, FIFO (pointer + count, no sub-module),
//   sticky ovf.
//
// TESTING
// - RZ loopback, CHANNELS=4, begin=0, end=8, lines driven 4'b1010 then 0 at subcycle 8
//   -> one word tdata=32'h0000_000A per cycle; err_o=0.
// - RC, ch0 sampled 1 at begin=2; line stays 1 at end=6
//   -> err_o[0]=1 and stays 1 until ctrl_en low; the word is still pushed with bit0=1.
// - tready held 0 for 6 pattern cycles, FIFO_DEPTH=4
//   -> tvalid=1 after the first push; 4 words held in order; ovf_o=1 after the 5th cycle.
//   When tready returns, the first 4 words drain unchanged.
// - FIFO full, tready=1 in the clock of hit_end -> push and pop both accepted; ovf_o stays 0.
// - Subcycle held for 10 clocks at the begin/end values -> exactly one sample and one push per
//   pattern cycle. begin=end=5 -> push with the new sample and no err change.
// - ctrl_en dropped with 3 words queued and err_o set -> next clock tvalid=0, err_o=0, ovf_o=0.
//   rst_n pulsed mid-cycle -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/wfg_record_pkg.sv
// Shared types and helpers for the pattern recorder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package wfg_record_pkg;

  // Per-channel line coding, matching the pattern driver encoding
  typedef enum logic [1:0] {
    PAT_RZ  = 2'b00,
    PAT_RO  = 2'b01,
    PAT_NRZ = 2'b10,
    PAT_RC  = 2'b11
  } patsel_e;

  localparam int AXIS_DATA_W = 32;
  localparam int CNT_W       = 8;

  // One-clock decode strobes derived from the aligned subcycle count
  typedef struct packed {
    logic hit_begin;
    logic hit_end;
  } hit_t;

  // Level a line must sit at when its return phase is checked
  function automatic logic expected_level(input patsel_e mode, input logic smp);
    logic lvl;
    case (mode)
      PAT_RZ:  lvl = 1'b0;
      PAT_RO:  lvl = 1'b1;
      PAT_NRZ: lvl = smp;
      default: lvl = ~smp;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/wfg_record_pat_channel.sv
// One pattern line: synchronizer, data sample, return-level check, sticky error.
// Latency: SYNC_STAGES clocks from pin to decode; word_bit is combinational on the hit.
// Backpressure: none; the channel samples whenever the top strobes a hit.
module wfg_record_pat_channel
  import wfg_record_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    pat,
  input  logic    hit_begin,
  input  logic    hit_end,
  input  logic    ctrl_en,
  input  patsel_e patsel,
  output logic    word_bit,
  output logic    err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line;
  logic                   smp_q;

  assign line = sync_q[SYNC_STAGES-1];

  // When begin and end coincide the pushed word must carry the fresh sample
  assign word_bit = hit_begin ? line : smp_q;

  // Synchronizer chain; keeps running while the block is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pat};
    end
  end

  // Data sample at the begin subcycle; cleared while disabled so a missed begin reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= 1'b0;
    end else if (!ctrl_en) begin
      smp_q <= 1'b0;
    end else if (hit_begin) begin
      smp_q <= line;
    end
  end

  // Sticky return-level error; skipped when sampling and checking share a subcycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (!ctrl_en) begin
      err <= 1'b0;
    end else if (hit_end && !hit_begin && (line != expected_level(patsel, smp_q))) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/wfg_record_pat.sv
// Pattern recorder: decodes CHANNELS serial lines into one AXI-Stream word per pattern cycle.
// Latency: SYNC_STAGES+1 clocks from the end-subcycle count change to tvalid on an empty FIFO.
// Backpressure: FIFO_DEPTH words buffered; a push into a full FIFO without a pop is dropped and sets ovf_o.
module wfg_record_pat
  import wfg_record_pkg::*;
#(
  parameter int CHANNELS    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_W-1:0]       pat_subcycle_cnt_i,
  input  logic                   ctrl_en_q_i,
  input  logic [2*CHANNELS-1:0]  patsel_q_i,
  input  logic [CNT_W-1:0]       cfg_begin_q_i,
  input  logic [CNT_W-1:0]       cfg_end_q_i,
  input  logic [CHANNELS-1:0]    pat_i,
  output logic [AXIS_DATA_W-1:0] wfg_axis_tdata_o,
  output logic                   wfg_axis_tvalid_o,
  input  logic                   wfg_axis_tready_i,
  output logic [CHANNELS-1:0]    err_o,
  output logic                   ovf_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------
  // Count alignment and event detection
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] cnt_pipe [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_prev;
  logic             prev_vld;
  logic             cnt_new;
  hit_t             hits;

  assign cnt_d = cnt_pipe[SYNC_STAGES-1];

  // Delay the subcycle count by the same depth as the line synchronizers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) cnt_pipe[i] <= '0;
    end else begin
      cnt_pipe[0] <= pat_subcycle_cnt_i;
      for (int i = 1; i < SYNC_STAGES; i++) cnt_pipe[i] <= cnt_pipe[i-1];
    end
  end

  // Remember the last aligned count so a subcycle spanning many clocks hits only once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vld <= 1'b0;
      cnt_prev <= '0;
    end else if (!ctrl_en_q_i) begin
      prev_vld <= 1'b0;
    end else begin
      prev_vld <= 1'b1;
      cnt_prev <= cnt_d;
    end
  end

  // One-clock strobes on the first clock of the begin/end subcycles
  always_comb begin
    cnt_new        = !prev_vld || (cnt_d != cnt_prev);
    hits.hit_begin = ctrl_en_q_i && cnt_new && (cnt_d == cfg_begin_q_i);
    hits.hit_end   = ctrl_en_q_i && cnt_new && (cnt_d == cfg_end_q_i);
  end

  // ---------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------
  logic [CHANNELS-1:0] word_bits;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    wfg_record_pat_channel #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pat       (pat_i[c]),
      .hit_begin (hits.hit_begin),
      .hit_end   (hits.hit_end),
      .ctrl_en   (ctrl_en_q_i),
      .patsel    (patsel_e'(patsel_q_i[2*c +: 2])),
      .word_bit  (word_bits[c]),
      .err       (err_o[c])
    );
  end

  // ---------------------------------------------------------------
  // Output word FIFO
  // ---------------------------------------------------------------
  logic [AXIS_DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AXIS_DATA_W-1:0] push_dat;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         fifo_cnt;
  logic                   fifo_full;
  logic                   push;
  logic                   push_ok;
  logic                   pop;

  // Zero-extend the channel bits to the stream width
  always_comb begin
    push_dat                 = '0;
    push_dat[CHANNELS-1:0]   = word_bits;
  end

  assign fifo_full         = (fifo_cnt == FULL_CNT);
  assign wfg_axis_tvalid_o = (fifo_cnt != '0);
  assign wfg_axis_tdata_o  = wfg_axis_tvalid_o ? mem[rd_ptr] : '0;
  assign push              = hits.hit_end;
  assign pop               = wfg_axis_tvalid_o && wfg_axis_tready_i;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign push_ok           = push && (!fifo_full || pop);

  // Pointers, occupancy and sticky overflow; disable flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf_o    <= 1'b0;
    end else if (!ctrl_en_q_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf_o    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && !push_ok) ovf_o <= 1'b1;
    end
  end

  // Storage; contents only matter behind valid occupancy, so no reset is needed
  always_ff @(posedge clk) begin
    if (ctrl_en_q_i && push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: tb/tb_wfg_record_pat.sv
// Bench for wfg_record_pat: vector table, hand sequences for FIFO/enable/reset corners,
// and randomized stimulus against a behavioural model kept alongside.
module tb_wfg_record_pat;

  localparam int CH    = 4;
  localparam int SS    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    cnt;
  logic          en;
  logic [2*CH-1:0] patsel;
  logic [7:0]    cfg_b;
  logic [7:0]    cfg_e;
  logic [CH-1:0] pat;
  logic [31:0]   tdata;
  logic          tvalid;
  logic          tready;
  logic [CH-1:0] err;
  logic          ovf;

  int n_pass = 0;
  int n_tot  = 0;
  bit mon_on = 1'b0;

  wfg_record_pat #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SS),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pat_subcycle_cnt_i (cnt),
    .ctrl_en_q_i        (en),
    .patsel_q_i         (patsel),
    .cfg_begin_q_i      (cfg_b),
    .cfg_end_q_i        (cfg_e),
    .pat_i              (pat),
    .wfg_axis_tdata_o   (tdata),
    .wfg_axis_tvalid_o  (tvalid),
    .wfg_axis_tready_i  (tready),
    .err_o              (err),
    .ovf_o              (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------
  // Behavioural model: delayed line/count, decoded word queue, sticky flags
  // ---------------------------------------------------------------
  logic [CH-1:0] m_pat [SS];
  logic [7:0]    m_cnt [SS];
  logic [31:0]   mq [$];
  logic [CH-1:0] m_err;
  logic [CH-1:0] m_smp;
  logic          m_ovf;
  logic          m_pv;
  logic [7:0]    m_cprev;

  task automatic model_step();
    logic [CH-1:0] line;
    logic [CH-1:0] nsmp;
    logic [7:0]    cd;
    logic          nw, hb, he, pop, lvl;
    int            sz;
    line = m_pat[SS-1];
    cd   = m_cnt[SS-1];
    if (!en) begin
      mq.delete();
      m_err = '0;
      m_ovf = 1'b0;
      m_pv  = 1'b0;
      m_smp = '0;
    end else begin
      nw   = !m_pv || (cd != m_cprev);
      hb   = nw && (cd == cfg_b);
      he   = nw && (cd == cfg_e);
      nsmp = hb ? line : m_smp;
      if (he && !hb) begin
        for (int c = 0; c < CH; c++) begin
          case (patsel[2*c +: 2])
            2'd0:    lvl = 1'b0;
            2'd1:    lvl = 1'b1;
            2'd2:    lvl = m_smp[c];
            default: lvl = ~m_smp[c];
          endcase
          if (line[c] !== lvl) m_err[c] = 1'b1;
        end
      end
      sz  = mq.size();
      pop = (sz > 0) && tready;
      if (pop) void'(mq.pop_front());
      if (he) begin
        if (sz == DEPTH && !pop) m_ovf = 1'b1;
        else mq.push_back({{(32-CH){1'b0}}, nsmp});
      end
      m_smp   = nsmp;
      m_pv    = 1'b1;
      m_cprev = cd;
    end
    for (int i = SS-1; i > 0; i--) begin
      m_pat[i] = m_pat[i-1];
      m_cnt[i] = m_cnt[i-1];
    end
    m_pat[0] = pat;
    m_cnt[0] = cnt;
  endtask

  // Model advances on the same edges as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SS; i++) begin
        m_pat[i] = '0;
        m_cnt[i] = '0;
      end
      mq.delete();
      m_err   = '0;
      m_smp   = '0;
      m_ovf   = 1'b0;
      m_pv    = 1'b0;
      m_cprev = '0;
    end else begin
      model_step();
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_tvalid", {31'b0, tvalid}, {31'b0, (mq.size() != 0)});
      if (mq.size() != 0) chk("mon_tdata", tdata, mq[0]);
      chk("mon_err", {28'b0, err}, {28'b0, m_err});
      chk("mon_ovf", {31'b0, ovf}, {31'b0, m_ovf});
    end
  end

  // One pattern cycle: subcycles 0..15, each held for 'hold' clocks
  task automatic run_cycle(input logic [CH-1:0] pb, input logic [CH-1:0] pe, input int hold);
    for (int s = 0; s < 16; s++) begin
      for (int h = 0; h < hold; h++) begin
        cnt = 8'(s);
        pat = (s >= int'(cfg_b) && s < int'(cfg_e)) ? pb : pe;
        @(negedge clk);
      end
    end
  endtask

  // Disable for a few clocks with a count that matches no configuration
  task automatic clear_block(input logic [7:0] ps, input logic [7:0] b, input logic [7:0] e);
    en     = 1'b0;
    cnt    = 8'hF0;
    pat    = '0;
    tready = 1'b0;
    patsel = ps;
    cfg_b  = b;
    cfg_e  = e;
    repeat (SS + 2) @(negedge clk);
    en = 1'b1;
  endtask

  typedef struct {
    logic [7:0]    psel;
    logic [7:0]    b;
    logic [7:0]    e;
    logic [CH-1:0] pb;
    logic [CH-1:0] pe;
    int            hold;
    logic [31:0]   word;
    logic [CH-1:0] err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] words [6];

    tbl[0]  = '{8'h00, 8'd0, 8'd8,  4'hA, 4'h0, 1,  32'h0000_000A, 4'h0};
    tbl[1]  = '{8'h00, 8'd0, 8'd8,  4'hA, 4'h3, 2,  32'h0000_000A, 4'h3};
    tbl[2]  = '{8'h55, 8'd2, 8'd6,  4'h5, 4'hF, 10, 32'h0000_0005, 4'h0};
    tbl[3]  = '{8'h55, 8'd2, 8'd6,  4'h5, 4'hC, 1,  32'h0000_0005, 4'h3};
    tbl[4]  = '{8'hAA, 8'd1, 8'd9,  4'h9, 4'h9, 3,  32'h0000_0009, 4'h0};
    tbl[5]  = '{8'hAA, 8'd1, 8'd9,  4'h9, 4'h3, 1,  32'h0000_0009, 4'hA};
    tbl[6]  = '{8'hFF, 8'd2, 8'd6,  4'h1, 4'hF, 2,  32'h0000_0001, 4'h1};
    tbl[7]  = '{8'hFF, 8'd2, 8'd6,  4'h6, 4'h9, 1,  32'h0000_0006, 4'h0};
    tbl[8]  = '{8'hE4, 8'd3, 8'd10, 4'hF, 4'h6, 1,  32'h0000_000F, 4'h0};
    tbl[9]  = '{8'hE4, 8'd3, 8'd10, 4'h0, 4'hF, 1,  32'h0000_0000, 4'h5};
    tbl[10] = '{8'h00, 8'd5, 8'd5,  4'h3, 4'h7, 10, 32'h0000_0007, 4'h0};

    rst_n = 1'b0; en = 1'b0; cnt = '0; patsel = '0; cfg_b = '0; cfg_e = '0;
    pat = '0; tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", {31'b0, tvalid}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_err", {28'b0, err}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Table: one pattern cycle per entry, then check and pop exactly one word
    for (int i = 0; i < 11; i++) begin
      clear_block(tbl[i].psel, tbl[i].b, tbl[i].e);
      run_cycle(tbl[i].pb, tbl[i].pe, tbl[i].hold);
      repeat (2) @(negedge clk);
      chk($sformatf("tbl%0d_vld", i), {31'b0, tvalid}, 32'd1);
      chk($sformatf("tbl%0d_dat", i), tdata, tbl[i].word);
      chk($sformatf("tbl%0d_err", i), {28'b0, err}, {28'b0, tbl[i].err});
      tready = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d_one", i), {31'b0, tvalid}, 32'd0);
      tready = 1'b0;
    end

    // Latency from the end-subcycle count change on an empty FIFO
    clear_block(8'h00, 8'd2, 8'd3);
    cnt = 8'd2; pat = 4'h9;
    repeat (4) @(negedge clk);
    cnt = 8'd3; pat = 4'h0;
    repeat (SS) @(negedge clk);
    chk("lat_early", {31'b0, tvalid}, 32'd0);
    @(negedge clk);
    chk("lat_vld", {31'b0, tvalid}, 32'd1);
    chk("lat_dat", tdata, 32'h9);

    // Six cycles with the sink stalled: four held in order, the rest dropped
    for (int i = 0; i < 6; i++) words[i] = 32'(i + 1);
    clear_block(8'h00, 8'd1, 8'd4);
    for (int i = 0; i < 6; i++) begin
      run_cycle(words[i][CH-1:0], 4'h0, 1);
      if (i == 0) chk("ovf_first_vld", {31'b0, tvalid}, 32'd1);
      if (i == 3) chk("ovf_not_yet", {31'b0, ovf}, 32'd0);
      if (i == 4) chk("ovf_set", {31'b0, ovf}, 32'd1);
    end
    tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d", i), tdata, words[i]);
      @(negedge clk);
    end
    chk("drain_empty", {31'b0, tvalid}, 32'd0);
    tready = 1'b0;

    // Full FIFO with a pop in the very clock of the push
    clear_block(8'h00, 8'd1, 8'd4);
    for (int i = 0; i < DEPTH; i++) run_cycle(words[i][CH-1:0], 4'h0, 1);
    for (int s = 0; s < 16; s++) begin
      cnt    = 8'(s);
      pat    = (s >= 1 && s < 4) ? words[4][CH-1:0] : 4'h0;
      tready = (s == 4 + SS);
      @(negedge clk);
    end
    tready = 1'b0;
    chk("fullpop_ovf", {31'b0, ovf}, 32'd0);
    tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("fullpop%0d", i), tdata, words[i+1]);
      @(negedge clk);
    end
    chk("fullpop_empty", {31'b0, tvalid}, 32'd0);
    tready = 1'b0;

    // Disable with words queued and errors set
    clear_block(8'hFF, 8'd2, 8'd6);
    for (int i = 0; i < 3; i++) run_cycle(4'h1, 4'hF, 1);
    chk("en_pre_vld", {31'b0, tvalid}, 32'd1);
    chk("en_pre_err", {28'b0, err}, 32'h1);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_vld", {31'b0, tvalid}, 32'd0);
    chk("en_off_err", {28'b0, err}, 32'd0);
    chk("en_off_ovf", {31'b0, ovf}, 32'd0);

    // Asynchronous reset mid-operation
    clear_block(8'hFF, 8'd2, 8'd6);
    run_cycle(4'h1, 4'hF, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", {31'b0, tvalid}, 32'd0);
    chk("arst_tdata", tdata, 32'd0);
    chk("arst_err", {28'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) cnt = 8'($urandom_range(0, 11));
      if ($urandom_range(0, 199) == 0) begin
        cfg_b = 8'($urandom_range(0, 11));
        cfg_e = 8'($urandom_range(0, 11));
      end
      if ($urandom_range(0, 99) == 0) patsel = 8'($urandom);
      pat    = 4'($urandom);
      tready = ($urandom_range(0, 2) != 0);
      en     = ($urandom_range(0, 149) != 0);
      @(negedge clk);
    end

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
